// File: rtl/branch_pkg.sv
// Shared types for the branch reservation station: branch kinds, entry payload
// and the CDB wakeup helper used for both stored entries and dispatch bypass.
package branch_pkg;

    localparam int unsigned TAG_W_DEFAULT = 5;
    localparam int unsigned XLEN          = 32;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_JAL  = 3'b111
    } branch_type_e;

    typedef struct packed {
        logic                     valid;
        logic [TAG_W_DEFAULT-1:0] rob_tag;
        logic [XLEN-1:0]          pc;
        logic [XLEN-1:0]          imm;
        branch_type_e             br_type;
        logic                     pred_taken;
        logic [XLEN-1:0]          pred_target;
        logic                     rs1_rdy;
        logic [TAG_W_DEFAULT-1:0] rs1_tag;
        logic [XLEN-1:0]          rs1_val;
        logic                     rs2_rdy;
        logic [TAG_W_DEFAULT-1:0] rs2_tag;
        logic [XLEN-1:0]          rs2_val;
    } branch_rs_entry_t;

    // Capture a CDB broadcast into any waiting operand of a valid entry.
    function automatic branch_rs_entry_t rs_wake(
        input branch_rs_entry_t         e,
        input logic                     cdb_valid,
        input logic [TAG_W_DEFAULT-1:0] cdb_tag,
        input logic [XLEN-1:0]          cdb_value
    );
        branch_rs_entry_t r;
        r = e;
        if (e.valid && cdb_valid) begin
            if (!e.rs1_rdy && e.rs1_tag == cdb_tag) begin
                r.rs1_rdy = 1'b1;
                r.rs1_val = cdb_value;
            end
            if (!e.rs2_rdy && e.rs2_tag == cdb_tag) begin
                r.rs2_rdy = 1'b1;
                r.rs2_val = cdb_value;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_rs_select.sv
// Oldest-first picker: finds the lowest-index set bit of the ready vector.
module branch_rs_select #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_ready,
    output logic [DEPTH-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (i_ready[i]) o_idx = IDX_W'(i);
        end
    end

    assign o_onehot = i_ready & (~i_ready + DEPTH'(1));
    assign o_any    = |i_ready;

endmodule

// File: rtl/branch_rs.sv
// Branch-unit reservation station: compacting age-ordered queue with CDB wakeup,
// dispatch bypass and oldest-ready issue over a valid/ready handshake.
module branch_rs
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = TAG_W_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [TAG_W-1:0] disp_rob_tag,
    input  logic [31:0]      disp_pc,
    input  logic [31:0]      disp_imm,
    input  logic [2:0]       disp_branch_type,
    input  logic             disp_pred_taken,
    input  logic [31:0]      disp_pred_target,
    input  logic             disp_rs1_rdy,
    input  logic [TAG_W-1:0] disp_rs1_tag,
    input  logic [31:0]      disp_rs1_val,
    input  logic             disp_rs2_rdy,
    input  logic [TAG_W-1:0] disp_rs2_tag,
    input  logic [31:0]      disp_rs2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             flush,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [TAG_W-1:0] iss_rob_tag,
    output logic [31:0]      iss_rs1_val,
    output logic [31:0]      iss_rs2_val,
    output logic [31:0]      iss_pc,
    output logic [31:0]      iss_imm,
    output logic [2:0]       iss_branch_type,
    output logic             iss_pred_taken,
    output logic [31:0]      iss_pred_target,
    output logic [CNT_W-1:0] count
);

    branch_rs_entry_t r_ent [DEPTH];
    logic [CNT_W-1:0] r_count;

    branch_rs_entry_t w_woken [DEPTH+1];
    branch_rs_entry_t w_next  [DEPTH];
    branch_rs_entry_t w_new;
    branch_rs_entry_t w_sel;
    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_sel_oh;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_any;
    logic             w_iss_fire;
    logic             w_disp_fire;
    logic [CNT_W-1:0] w_wr_idx;
    logic [CNT_W-1:0] w_count_next;
    logic [TAG_W_DEFAULT-1:0] w_cdb_tag;

    assign w_cdb_tag = TAG_W_DEFAULT'(cdb_tag);

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_ent[i].valid & r_ent[i].rs1_rdy & r_ent[i].rs2_rdy;
        end
    end

    branch_rs_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .i_ready  (w_ready),
        .o_onehot (w_sel_oh),
        .o_idx    (w_sel_idx),
        .o_any    (w_sel_any)
    );

    // AND-OR mux leaves every field zero when nothing is selected.
    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_sel_oh[i]) w_sel = w_sel | r_ent[i];
        end
    end

    assign iss_valid       = w_sel_any;
    assign iss_rob_tag     = TAG_W'(w_sel.rob_tag);
    assign iss_rs1_val     = w_sel.rs1_val;
    assign iss_rs2_val     = w_sel.rs2_val;
    assign iss_pc          = w_sel.pc;
    assign iss_imm         = w_sel.imm;
    assign iss_branch_type = w_sel.br_type;
    assign iss_pred_taken  = w_sel.pred_taken;
    assign iss_pred_target = w_sel.pred_target;
    assign disp_ready      = (r_count < CNT_W'(DEPTH));
    assign count           = r_count;

    assign w_iss_fire  = iss_valid & iss_ready;
    assign w_disp_fire = disp_valid & disp_ready;
    assign w_wr_idx    = r_count - CNT_W'(w_iss_fire);

    // Incoming µop, with operands captured from a coincident CDB broadcast.
    always_comb begin
        w_new             = '0;
        w_new.valid       = 1'b1;
        w_new.rob_tag     = TAG_W_DEFAULT'(disp_rob_tag);
        w_new.pc          = disp_pc;
        w_new.imm         = disp_imm;
        w_new.br_type     = branch_type_e'(disp_branch_type);
        w_new.pred_taken  = disp_pred_taken;
        w_new.pred_target = disp_pred_target;
        w_new.rs1_rdy     = disp_rs1_rdy;
        w_new.rs1_tag     = TAG_W_DEFAULT'(disp_rs1_tag);
        w_new.rs1_val     = disp_rs1_val;
        w_new.rs2_rdy     = disp_rs2_rdy;
        w_new.rs2_tag     = TAG_W_DEFAULT'(disp_rs2_tag);
        w_new.rs2_val     = disp_rs2_val;
        w_new             = rs_wake(w_new, cdb_valid, w_cdb_tag, cdb_value);
    end

    // Wakeup, then compaction over the issued slot, then dispatch write.
    always_comb begin
        w_woken[DEPTH] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_woken[i] = rs_wake(r_ent[i], cdb_valid, w_cdb_tag, cdb_value);
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_next[i] = w_woken[i];
            if (w_iss_fire && i >= 32'(w_sel_idx)) w_next[i] = w_woken[i+1];
            if (w_disp_fire && CNT_W'(i) == w_wr_idx) w_next[i] = w_new;
            if (flush) w_next[i] = '0;
        end
        w_count_next = r_count + CNT_W'(w_disp_fire) - CNT_W'(w_iss_fire);
        if (flush) w_count_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_count <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= w_next[i];
            r_count <= w_count_next;
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: issue order, wakeup, bypass, full, flush, reset.
module tb_branch_rs;

    logic        clk;
    logic        rst_n;
    logic        disp_valid;
    logic        disp_ready;
    logic [4:0]  disp_rob_tag;
    logic [31:0] disp_pc;
    logic [31:0] disp_imm;
    logic [2:0]  disp_branch_type;
    logic        disp_pred_taken;
    logic [31:0] disp_pred_target;
    logic        disp_rs1_rdy;
    logic [4:0]  disp_rs1_tag;
    logic [31:0] disp_rs1_val;
    logic        disp_rs2_rdy;
    logic [4:0]  disp_rs2_tag;
    logic [31:0] disp_rs2_val;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        flush;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rob_tag;
    logic [31:0] iss_rs1_val;
    logic [31:0] iss_rs2_val;
    logic [31:0] iss_pc;
    logic [31:0] iss_imm;
    logic [2:0]  iss_branch_type;
    logic        iss_pred_taken;
    logic [31:0] iss_pred_target;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    branch_rs #(.DEPTH(4), .TAG_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .disp_valid       (disp_valid),
        .disp_ready       (disp_ready),
        .disp_rob_tag     (disp_rob_tag),
        .disp_pc          (disp_pc),
        .disp_imm         (disp_imm),
        .disp_branch_type (disp_branch_type),
        .disp_pred_taken  (disp_pred_taken),
        .disp_pred_target (disp_pred_target),
        .disp_rs1_rdy     (disp_rs1_rdy),
        .disp_rs1_tag     (disp_rs1_tag),
        .disp_rs1_val     (disp_rs1_val),
        .disp_rs2_rdy     (disp_rs2_rdy),
        .disp_rs2_tag     (disp_rs2_tag),
        .disp_rs2_val     (disp_rs2_val),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_value        (cdb_value),
        .flush            (flush),
        .iss_valid        (iss_valid),
        .iss_ready        (iss_ready),
        .iss_rob_tag      (iss_rob_tag),
        .iss_rs1_val      (iss_rs1_val),
        .iss_rs2_val      (iss_rs2_val),
        .iss_pc           (iss_pc),
        .iss_imm          (iss_imm),
        .iss_branch_type  (iss_branch_type),
        .iss_pred_taken   (iss_pred_taken),
        .iss_pred_target  (iss_pred_target),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [4:0] tag, input logic [31:0] pc,
                            input logic r1rdy, input logic [4:0] r1tag, input logic [31:0] r1val,
                            input logic r2rdy, input logic [4:0] r2tag, input logic [31:0] r2val);
        disp_valid   = 1'b1;
        disp_rob_tag = tag;
        disp_pc      = pc;
        disp_rs1_rdy = r1rdy;
        disp_rs1_tag = r1tag;
        disp_rs1_val = r1val;
        disp_rs2_rdy = r2rdy;
        disp_rs2_tag = r2tag;
        disp_rs2_val = r2val;
    endtask

    initial begin
        rst_n = 1'b0; disp_valid = 1'b0; disp_rob_tag = '0; disp_pc = '0; disp_imm = 32'd100;
        disp_branch_type = 3'b000; disp_pred_taken = 1'b0; disp_pred_target = '0;
        disp_rs1_rdy = 1'b0; disp_rs1_tag = '0; disp_rs1_val = '0;
        disp_rs2_rdy = 1'b0; disp_rs2_tag = '0; disp_rs2_val = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; flush = 1'b0; iss_ready = 1'b0;

        repeat (2) tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_iss_pc", iss_pc, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single ready BEQ issues the cycle after dispatch.
        set_disp(5'd3, 32'h1000, 1'b1, 5'd0, 32'd10, 1'b1, 5'd0, 32'd10);
        disp_pred_taken = 1'b1; disp_pred_target = 32'h2000;
        chk("t1_empty_no_issue", 32'(iss_valid), 32'd0);
        tick();
        disp_valid = 1'b0;
        chk("t1_iss_valid", 32'(iss_valid), 32'd1);
        chk("t1_rob_tag", 32'(iss_rob_tag), 32'd3);
        chk("t1_pc", iss_pc, 32'h1000);
        chk("t1_imm", iss_imm, 32'd100);
        chk("t1_rs1", iss_rs1_val, 32'd10);
        chk("t1_rs2", iss_rs2_val, 32'd10);
        chk("t1_type", 32'(iss_branch_type), 32'd0);
        chk("t1_pred_taken", 32'(iss_pred_taken), 32'd1);
        chk("t1_pred_target", iss_pred_target, 32'h2000);
        chk("t1_count", 32'(count), 32'd1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0; disp_pred_taken = 1'b0; disp_pred_target = '0;
        chk("t1_count_after", 32'(count), 32'd0);
        chk("t1_valid_after", 32'(iss_valid), 32'd0);

        // Younger ready entry bypasses an older waiting one; CDB wakes the older.
        set_disp(5'd4, 32'h1100, 1'b0, 5'd7, 32'd0, 1'b1, 5'd0, 32'd1);
        disp_branch_type = 3'b001;
        tick();
        chk("t2_wait_not_valid", 32'(iss_valid), 32'd0);
        set_disp(5'd5, 32'h1200, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 32'd3);
        disp_branch_type = 3'b100;
        tick();
        disp_valid = 1'b0;
        chk("t2_b_first", 32'(iss_rob_tag), 32'd5);
        chk("t2_b_type", 32'(iss_branch_type), 32'd4);
        chk("t2_count", 32'(count), 32'd2);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        chk("t2_after_b_valid", 32'(iss_valid), 32'd0);
        chk("t2_after_b_count", 32'(count), 32'd1);
        cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'h55;
        #1;
        chk("t2_wake_not_same_cycle", 32'(iss_valid), 32'd0);
        tick();
        cdb_valid = 1'b0;
        chk("t2_a_valid", 32'(iss_valid), 32'd1);
        chk("t2_a_tag", 32'(iss_rob_tag), 32'd4);
        chk("t2_a_rs1", iss_rs1_val, 32'h55);
        chk("t2_a_rs2", iss_rs2_val, 32'd1);
        chk("t2_a_type", 32'(iss_branch_type), 32'd1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        chk("t2_count_end", 32'(count), 32'd0);

        // Dispatch bypass of rs2 from a same-cycle broadcast.
        disp_branch_type = 3'b000;
        set_disp(5'd6, 32'h1300, 1'b1, 5'd0, 32'd7, 1'b0, 5'd9, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 32'd20;
        tick();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        chk("t3_valid", 32'(iss_valid), 32'd1);
        chk("t3_rs1", iss_rs1_val, 32'd7);
        chk("t3_rs2", iss_rs2_val, 32'd20);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        chk("t3_count_end", 32'(count), 32'd0);

        // Both operands woken by one broadcast.
        set_disp(5'd19, 32'h1400, 1'b0, 5'd20, 32'd0, 1'b0, 5'd20, 32'd0);
        tick();
        disp_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_value = 32'h99;
        tick();
        cdb_valid = 1'b0;
        chk("t3b_valid", 32'(iss_valid), 32'd1);
        chk("t3b_rs1", iss_rs1_val, 32'h99);
        chk("t3b_rs2", iss_rs2_val, 32'h99);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;

        // Fill to DEPTH; overflow dispatch dropped; no same-cycle credit.
        for (int i = 0; i < 4; i++) begin
            set_disp(5'(8 + i), 32'h2000 + 32'(i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'd0);
            tick();
        end
        disp_valid = 1'b0;
        chk("t4_count_full", 32'(count), 32'd4);
        chk("t4_disp_ready", 32'(disp_ready), 32'd0);
        chk("t4_oldest", 32'(iss_rob_tag), 32'd8);
        set_disp(5'd12, 32'h3000, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
        tick();
        chk("t4_drop_count", 32'(count), 32'd4);
        set_disp(5'd13, 32'h3100, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
        iss_ready = 1'b1;
        #1;
        chk("t4_no_credit", 32'(disp_ready), 32'd0);
        tick();
        disp_valid = 1'b0; iss_ready = 1'b0;
        chk("t4_count_after_issue", 32'(count), 32'd3);
        chk("t4_disp_ready_after", 32'(disp_ready), 32'd1);
        chk("t4_next_oldest", 32'(iss_rob_tag), 32'd9);

        // Issue and dispatch together at count=2 keep order.
        iss_ready = 1'b1;
        tick();
        chk("t5_count2", 32'(count), 32'd2);
        chk("t5_head", 32'(iss_rob_tag), 32'd10);
        set_disp(5'd14, 32'h3200, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
        tick();
        disp_valid = 1'b0; iss_ready = 1'b0;
        chk("t5_count_stays", 32'(count), 32'd2);
        chk("t5_survivor_head", 32'(iss_rob_tag), 32'd11);
        chk("t5_survivor_pc", iss_pc, 32'h2003);
        iss_ready = 1'b1;
        tick();
        chk("t5_new_second", 32'(iss_rob_tag), 32'd14);
        tick();
        iss_ready = 1'b0;
        chk("t5_count_end", 32'(count), 32'd0);

        // Flush beats a concurrent dispatch and issue.
        for (int i = 0; i < 3; i++) begin
            set_disp(5'(15 + i), 32'h4000, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
            tick();
        end
        chk("t6_count3", 32'(count), 32'd3);
        set_disp(5'd18, 32'h4100, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
        flush = 1'b1; iss_ready = 1'b1;
        tick();
        flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
        chk("t6_flush_count", 32'(count), 32'd0);
        chk("t6_flush_valid", 32'(iss_valid), 32'd0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 2; i++) begin
            set_disp(5'(21 + i), 32'h5000, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd6);
            tick();
        end
        disp_valid = 1'b0;
        chk("t7_count2", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_count", 32'(count), 32'd0);
        chk("t7_async_valid", 32'(iss_valid), 32'd0);
        chk("t7_async_tag", 32'(iss_rob_tag), 32'd0);
        chk("t7_async_rs1", iss_rs1_val, 32'd0);
        chk("t7_async_ready", 32'(disp_ready), 32'd1);
        #2 rst_n = 1'b1;
        tick();
        chk("t7_post_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
